fetch_unit: RTL and testbench

Owns the architectural PC and fetches instructions from instruction memory for the multi-cycle core. It consumes the next-address result, a redirect target from branch/jump resolution, and otherwise advances sequentially by 4. It issues one request at a time over a valid/ready handshake. It holds each fetched instruction in a one-entry buffer until decode accepts it.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/Adder32_p.sv | 9 +
 rtl/inst_buffer.sv | 34 +++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the fetch unit: FSM state encodings, reset PC and the
// sequential PC step.
package fetch_pkg;
   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [31:0] PC_STEP      = 32'h4;

   typedef logic [2:0] fetch_state_t;
   localparam fetch_state_t ST_IDLE  = 3'd0;
   localparam fetch_state_t ST_FETCH = 3'd1;
   localparam fetch_state_t ST_WAIT  = 3'd2;
   localparam fetch_state_t ST_HOLD  = 3'd3;
   localparam fetch_state_t ST_FAULT = 3'd4;
endpackage

// File: rtl/Adder32_p.sv
// 32-bit add/subtract; sub_i=1 computes a_i - b_i via two's complement.
module Adder32_p (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        sub_i,
   output logic [31:0] sum_o
);
   assign sum_o = a_i + (b_i ^ {32{sub_i}}) + {31'b0, sub_i};
endmodule

// File: rtl/inst_buffer.sv
// One-entry instruction buffer: holds a fetched word and its PC until cleared.
module inst_buffer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] data_i,
   input  logic [31:0] pc_i,
   output logic        valid_o,
   output logic [31:0] data_o,
   output logic [31:0] pc_o
);
   logic        valid_q;
   logic [31:0] data_q, pc_q;

   // Clear wins over load so a redirect always empties the entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pc_q    <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         pc_q    <= pc_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem request at a time and parks
// the returned word in a one-entry buffer until decode takes it.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        fetch_fault
);
   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d, req_pc_q, req_pc_d, pc_inc;
   logic         stale_q, stale_d, fpend_q, fpend_d;
   logic         accept, misal, buf_load, buf_clear;

   Adder32_p u_inc (.a_i(pc_q), .b_i(PC_STEP), .sub_i(1'b0), .sum_o(pc_inc));

   assign accept = (state_q == ST_FETCH) && imem_req_ready;
   assign misal  = |redirect_pc[1:0];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      stale_d   = stale_q;
      fpend_d   = fpend_q;
      buf_load  = 1'b0;
      buf_clear = 1'b0;
      if (redirect) begin
         pc_d = redirect_pc;
         case (state_q)
            ST_FETCH: begin
               if (accept) begin
                  // Request leaves with the old address; its response is junk.
                  req_pc_d = pc_q;
                  stale_d  = 1'b1;
                  fpend_d  = misal;
                  state_d  = ST_WAIT;
               end else begin
                  state_d = misal ? ST_FAULT : ST_FETCH;
               end
            end
            ST_WAIT: begin
               if (imem_resp_valid) begin
                  stale_d = 1'b0;
                  fpend_d = 1'b0;
                  state_d = misal ? ST_FAULT : ST_FETCH;
               end else begin
                  stale_d = 1'b1;
                  fpend_d = misal;
               end
            end
            ST_HOLD: begin
               buf_clear = 1'b1;
               state_d   = misal ? ST_FAULT : ST_FETCH;
            end
            default: state_d = misal ? ST_FAULT : ST_FETCH;
         endcase
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
               if (accept) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_inc;
                  state_d  = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_resp_valid) begin
                  if (stale_q) begin
                     stale_d = 1'b0;
                     fpend_d = 1'b0;
                     state_d = fpend_q ? ST_FAULT : ST_FETCH;
                  end else begin
                     buf_load = 1'b1;
                     state_d  = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (inst_ready) begin
                  buf_clear = 1'b1;
                  state_d   = ST_FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
         stale_q  <= 1'b0;
         fpend_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         stale_q  <= stale_d;
         fpend_q  <= fpend_d;
      end
   end

   inst_buffer u_buf (
      .clk     (clk),
      .rst     (rst),
      .load_i  (buf_load),
      .clear_i (buf_clear),
      .data_i  (imem_resp_data),
      .pc_i    (req_pc_q),
      .valid_o (inst_valid),
      .data_o  (inst),
      .pc_o    (inst_pc)
   );

   assign imem_req_valid = (state_q == ST_FETCH);
   assign imem_req_addr  = pc_q;
   assign fetch_fault    = (state_q == ST_FAULT);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected request addresses and delivered
// instructions are queued by the stimulus and popped as the DUT produces them.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        inst_valid;
   logic [31:0] inst, inst_pc;
   logic        inst_ready = 1'b0;
   logic        fetch_fault;

   // second instance exercising PC wrap
   logic        w_req_valid, w_inst_valid, w_fault;
   logic [31:0] w_req_addr, w_inst, w_inst_pc;
   logic        w_resp_valid = 1'b0;
   logic [31:0] w_resp_data = '0;
   logic        w_acc = 1'b0;
   logic [31:0] w_a0 = '0, w_a1 = '0;
   int          w_n = 0;

   int          errs = 0, checks = 0;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_ipc[$];
   int          lat = 1, due = 0;
   logic [31:0] resp_word = '0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst(inst),
      .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_fault(fetch_fault)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(32'h0),
      .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
      .imem_req_ready(1'b1), .imem_resp_valid(w_resp_valid),
      .imem_resp_data(w_resp_data), .inst_valid(w_inst_valid), .inst(w_inst),
      .inst_pc(w_inst_pc), .inst_ready(1'b1), .fetch_fault(w_fault)
   );

   // wrap instance memory: always ready, one-cycle response
   always @(negedge clk) begin
      w_resp_valid = w_acc;
      w_resp_data  = 32'h0000_0013;
      w_acc        = w_req_valid;
      if (w_req_valid && w_n < 2) begin
         if (w_n == 0) w_a0 = w_req_addr;
         else          w_a1 = w_req_addr;
         w_n++;
      end
   end

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs for the coming edge are already set; this adds the memory
   // response, scores what the edge will transfer, then advances to negedge.
   task automatic cycle();
      logic [31:0] e;
      imem_resp_valid = (due == 1);
      imem_resp_data  = (due == 1) ? resp_word : $urandom;
      if (due > 0) due--;
      if (imem_req_valid && imem_req_ready) begin
         chk("req_expected", (exp_addr.size() != 0) ? 32'd1 : 32'd0, 32'd1);
         if (exp_addr.size() != 0) begin
            e = exp_addr.pop_front();
            chk("req_addr", imem_req_addr, e);
         end
         resp_word = word_of(imem_req_addr);
         due = lat;
      end
      if (inst_valid && inst_ready && !redirect) begin
         chk("inst_expected", (exp_ipc.size() != 0) ? 32'd1 : 32'd0, 32'd1);
         if (exp_ipc.size() != 0) begin
            e = exp_ipc.pop_front();
            chk("inst_pc", inst_pc, e);
            chk("inst", inst, word_of(e));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int max);
      int n = 0;
      while ((exp_addr.size() != 0 || exp_ipc.size() != 0) && n < max) begin
         cycle();
         n++;
      end
      chk("drain", exp_addr.size() + exp_ipc.size(), 0);
      exp_addr.delete();
      exp_ipc.delete();
   endtask

   task automatic wait_inst(input int max);
      int n = 0;
      while (!inst_valid && n < max) begin
         cycle();
         n++;
      end
      chk("inst_valid_wait", {31'b0, inst_valid}, 1);
   endtask

   initial begin
      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
      chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
      chk("rst_inst_valid", {31'b0, inst_valid}, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_fault", {31'b0, fetch_fault}, 0);
      rst = 1'b0;
      chk("idle_req_valid", {31'b0, imem_req_valid}, 0);
      cycle();
      chk("first_req_valid", {31'b0, imem_req_valid}, 1);
      chk("first_req_addr", imem_req_addr, 32'h8000_0000);

      // back-to-back sequential fetches
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_addr.push_back(32'h8000_0000 + 32'(i * 4));
         exp_ipc.push_back(32'h8000_0000 + 32'(i * 4));
      end
      run(20);
      imem_req_ready = 1'b0;

      // memory not ready for 5 cycles: request held stable
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall_valid", {31'b0, imem_req_valid}, 1);
         chk("stall_addr", imem_req_addr, 32'h8000_000C);
      end
      imem_req_ready = 1'b1;
      exp_addr.push_back(32'h8000_000C);
      exp_ipc.push_back(32'h8000_000C);
      run(20);
      imem_req_ready = 1'b0;

      // decode stalls in HOLD for 4 cycles
      exp_addr.push_back(32'h8000_0010);
      imem_req_ready = 1'b1;
      inst_ready = 1'b0;
      wait_inst(10);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("hold_inst", inst, word_of(32'h8000_0010));
         chk("hold_pc", inst_pc, 32'h8000_0010);
         chk("hold_no_req", {31'b0, imem_req_valid}, 0);
      end
      exp_ipc.push_back(32'h8000_0010);
      inst_ready = 1'b1;
      imem_req_ready = 1'b0;
      cycle();
      chk("release_req_valid", {31'b0, imem_req_valid}, 1);
      chk("release_req_addr", imem_req_addr, 32'h8000_0014);
      run(5);

      // redirect while waiting; late response must be dropped
      exp_addr.push_back(32'h8000_0014);
      imem_req_ready = 1'b1;
      lat = 3;
      cycle();
      imem_req_ready = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h8000_0100;
      cycle();
      redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("drop_no_inst", {31'b0, inst_valid}, 0);
      end
      chk("redir_req_valid", {31'b0, imem_req_valid}, 1);
      chk("redir_req_addr", imem_req_addr, 32'h8000_0100);
      lat = 1;
      exp_addr.push_back(32'h8000_0100);
      exp_ipc.push_back(32'h8000_0100);
      imem_req_ready = 1'b1;
      run(20);
      imem_req_ready = 1'b0;

      // redirect coincident with inst_ready in HOLD
      exp_addr.push_back(32'h8000_0104);
      imem_req_ready = 1'b1;
      inst_ready = 1'b0;
      wait_inst(10);
      imem_req_ready = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h8000_0100;
      inst_ready = 1'b1;
      cycle();
      redirect = 1'b0;
      chk("hold_redir_inst_valid", {31'b0, inst_valid}, 0);
      chk("hold_redir_req_addr", imem_req_addr, 32'h8000_0100);
      exp_addr.push_back(32'h8000_0100);
      exp_ipc.push_back(32'h8000_0100);
      imem_req_ready = 1'b1;
      run(20);
      imem_req_ready = 1'b0;

      // misaligned redirect from FETCH
      redirect = 1'b1;
      redirect_pc = 32'h8000_0102;
      cycle();
      redirect = 1'b0;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("fault_set", {31'b0, fetch_fault}, 1);
         chk("fault_no_req", {31'b0, imem_req_valid}, 0);
         chk("fault_no_inst", {31'b0, inst_valid}, 0);
         cycle();
      end
      redirect = 1'b1;
      redirect_pc = 32'h8000_0200;
      imem_req_ready = 1'b0;
      cycle();
      redirect = 1'b0;
      chk("fault_clear", {31'b0, fetch_fault}, 0);
      exp_addr.push_back(32'h8000_0200);
      exp_ipc.push_back(32'h8000_0200);
      imem_req_ready = 1'b1;
      run(20);
      imem_req_ready = 1'b0;

      // misaligned redirect in WAIT: fault only after response drains
      exp_addr.push_back(32'h8000_0204);
      imem_req_ready = 1'b1;
      lat = 3;
      cycle();
      imem_req_ready = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h8000_0302;
      cycle();
      redirect = 1'b0;
      cycle();
      chk("wait_fault_pending", {31'b0, fetch_fault}, 0);
      cycle();
      chk("wait_fault_set", {31'b0, fetch_fault}, 1);
      chk("wait_fault_no_inst", {31'b0, inst_valid}, 0);
      lat = 1;
      redirect = 1'b1;
      redirect_pc = 32'h8000_0400;
      cycle();
      redirect = 1'b0;
      exp_addr.push_back(32'h8000_0400);
      exp_ipc.push_back(32'h8000_0400);
      imem_req_ready = 1'b1;
      run(20);

      // PC wrap on the second instance
      chk("wrap_first", w_a0, 32'hFFFF_FFFC);
      chk("wrap_second", w_a1, 32'h0000_0000);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
